// File: rtl/adc_dac_test_sequencer.sv
// rtl/adc_dac_test_sequencer.sv - ADC/DAC bring-up sequencer: driver reset pulse, DAC routing, LED and min/max tracking
//
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   adc_in        N_CH packed ADC samples, channel k at [k*W +: W]
//   auto_en_in    enable periodic auto-reset
//   trig_in       single-cycle manual reset request (honoured in RUN only)
//   sel0_in       channel routed to DAC0, also drives LEDs and min/max
//   sel1_in       channel routed to DAC1
//   mode0_in      DAC0 mode: 0 copy, 1 invert, 2 ramp, 3 hold
//   mode1_in      DAC1 mode, same encoding
//   clr_stats_in  reload min/max to their empty values
//   rst_out       reset to the ADC/DAC drivers
//   ready_out     high while in RUN
//   dac0_out      DAC0 sample
//   dac1_out      DAC1 sample
//   led_out       inverted MSBs of channel sel0_in
//   min_out       signed minimum of channel sel0_in since clear
//   max_out       signed maximum of channel sel0_in since clear

module adc_dac_test_sequencer #(
    parameter int N_CH       = 4,
    parameter int W          = 16,
    parameter int PRESCALE   = 100,
    parameter int PERIOD     = 10000000,
    parameter int RST_LEN    = 1000000,
    parameter int SETTLE_LEN = 1000,
    parameter int LED_BITS   = 4,
    parameter int RAMP_STEP  = 8,
    localparam int SW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [N_CH*W-1:0]   adc_in,
    input  logic                auto_en_in,
    input  logic                trig_in,
    input  logic [SW-1:0]       sel0_in,
    input  logic [SW-1:0]       sel1_in,
    input  logic [1:0]          mode0_in,
    input  logic [1:0]          mode1_in,
    input  logic                clr_stats_in,
    output logic                rst_out,
    output logic                ready_out,
    output logic [W-1:0]        dac0_out,
    output logic [W-1:0]        dac1_out,
    output logic [LED_BITS-1:0] led_out,
    output logic [W-1:0]        min_out,
    output logic [W-1:0]        max_out
);

    localparam int PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RUN_LEN = PERIOD - RST_LEN - SETTLE_LEN;

    localparam logic [W-1:0] MID    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] POSMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] STEP   = W'(RAMP_STEP);

    localparam logic [1:0] M_COPY   = 2'd0;
    localparam logic [1:0] M_INVERT = 2'd1;
    localparam logic [1:0] M_RAMP   = 2'd2;

    typedef enum logic [1:0] {
        S_RST_HOLD = 2'd0,
        S_SETTLE   = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t         state;
    logic [PW-1:0]  presc;
    logic [31:0]    tick_cnt;
    logic           tick;
    logic           run;
    logic [W-1:0]   ch0_s;
    logic [W-1:0]   ch1_s;
    logic [W-1:0]   ramp0;
    logic [W-1:0]   ramp1;

    assign tick = (presc == PW'(PRESCALE - 1));
    assign run  = (state == S_RUN);

    // Channel mux; any select value without a matching channel falls back to channel 0.
    always_comb begin
        ch0_s = adc_in[W-1:0];
        ch1_s = adc_in[W-1:0];
        for (int k = 0; k < N_CH; k++) begin
            if (sel0_in == SW'(k)) ch0_s = adc_in[k*W +: W];
            if (sel1_in == SW'(k)) ch1_s = adc_in[k*W +: W];
        end
    end

    function automatic logic [W-1:0] route(input logic [1:0] mode, input logic [W-1:0] ch,
                                           input logic [W-1:0] ramp, input logic [W-1:0] cur);
        case (mode)
            M_COPY:   route = ch;
            M_INVERT: route = ~ch;
            M_RAMP:   route = ramp;
            default:  route = cur;
        endcase
    endfunction

    // Sequencer: prescaler, tick counter and the reset/settle/run state machine.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_RST_HOLD;
            presc     <= '0;
            tick_cnt  <= '0;
            rst_out   <= 1'b1;
            ready_out <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            case (state)
                S_RST_HOLD: begin
                    if (tick) begin
                        if (tick_cnt >= 32'(RST_LEN - 1)) begin
                            state    <= S_SETTLE;
                            rst_out  <= 1'b0;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 32'd1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (tick) begin
                        if (tick_cnt >= 32'(SETTLE_LEN - 1)) begin
                            state     <= S_RUN;
                            ready_out <= 1'b1;
                            tick_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 32'd1;
                        end
                    end
                end
                S_RUN: begin
                    // A manual trigger and an auto-expiry in the same cycle collapse into one restart.
                    if (trig_in || (tick && auto_en_in && tick_cnt >= 32'(RUN_LEN - 1))) begin
                        state     <= S_RST_HOLD;
                        rst_out   <= 1'b1;
                        ready_out <= 1'b0;
                        tick_cnt  <= '0;
                    end else if (tick && tick_cnt < 32'(RUN_LEN - 1)) begin
                        // Saturates at the expiry value so enabling auto-reset later restarts on the next tick.
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                default: begin
                    state     <= S_RST_HOLD;
                    rst_out   <= 1'b1;
                    ready_out <= 1'b0;
                    tick_cnt  <= '0;
                end
            endcase
        end
    end

    // DAC routing. A ramp register sits at midscale whenever its output is not ramping in RUN,
    // so entering ramp mode always starts the sequence at midscale.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dac0_out <= '0;
            dac1_out <= '0;
            ramp0    <= MID;
            ramp1    <= MID;
        end else begin
            ramp0 <= (run && mode0_in == M_RAMP) ? ramp0 + STEP : MID;
            ramp1 <= (run && mode1_in == M_RAMP) ? ramp1 + STEP : MID;
            if (run) begin
                dac0_out <= route(mode0_in, ch0_s, ramp0, dac0_out);
                dac1_out <= route(mode1_in, ch1_s, ramp1, dac1_out);
            end else begin
                dac0_out <= '0;
                dac1_out <= '0;
            end
        end
    end

    // LEDs follow the sel0 channel in every state; min/max only track while in RUN.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            led_out <= '1;
            min_out <= POSMAX;
            max_out <= MID;
        end else begin
            led_out <= ~ch0_s[W-1 -: LED_BITS];
            if (clr_stats_in) begin
                min_out <= POSMAX;
                max_out <= MID;
            end else if (run) begin
                if ($signed(ch0_s) < $signed(min_out)) min_out <= ch0_s;
                if ($signed(ch0_s) > $signed(max_out)) max_out <= ch0_s;
            end
        end
    end

endmodule

// File: tb/tb_adc_dac_test_sequencer.sv
// tb/tb_adc_dac_test_sequencer.sv - directed self-checking bench for adc_dac_test_sequencer
module tb_adc_dac_test_sequencer;

    localparam int N_CH = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst_in;
    logic [N_CH*W-1:0] adc_in;
    logic              auto_en_in;
    logic              trig_in;
    logic [1:0]        sel0_in;
    logic [1:0]        sel1_in;
    logic [1:0]        mode0_in;
    logic [1:0]        mode1_in;
    logic              clr_stats_in;
    logic              rst_out;
    logic              ready_out;
    logic [W-1:0]      dac0_out;
    logic [W-1:0]      dac1_out;
    logic [3:0]        led_out;
    logic [W-1:0]      min_out;
    logic [W-1:0]      max_out;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    adc_dac_test_sequencer #(
        .N_CH(N_CH), .W(W), .PRESCALE(2), .PERIOD(20), .RST_LEN(3), .SETTLE_LEN(2),
        .LED_BITS(4), .RAMP_STEP(8)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .adc_in(adc_in), .auto_en_in(auto_en_in),
        .trig_in(trig_in), .sel0_in(sel0_in), .sel1_in(sel1_in), .mode0_in(mode0_in),
        .mode1_in(mode1_in), .clr_stats_in(clr_stats_in), .rst_out(rst_out),
        .ready_out(ready_out), .dac0_out(dac0_out), .dac1_out(dac1_out),
        .led_out(led_out), .min_out(min_out), .max_out(max_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Steps until rst_out goes low->high; n is the number of cycles taken (capped at 200).
    task automatic wait_rise(output int cnt);
        logic prev;
        logic seen;
        cnt  = 0;
        seen = 1'b0;
        prev = rst_out;
        while (!seen && cnt < 200) begin
            step();
            cnt++;
            if (!prev && rst_out) seen = 1'b1;
            prev = rst_out;
        end
    endtask

    initial begin
        rst_in = 1'b1; adc_in = '0; auto_en_in = 1'b0; trig_in = 1'b0;
        sel0_in = 2'd0; sel1_in = 2'd0; mode0_in = 2'd0; mode1_in = 2'd0; clr_stats_in = 1'b0;
        repeat (3) step();
        check("rst_rst_out", rst_out, 1);
        check("rst_ready", ready_out, 0);
        check("rst_dac0", dac0_out, 0);
        check("rst_dac1", dac1_out, 0);
        check("rst_led", led_out, 4'hF);
        check("rst_min", min_out, 16'h7FFF);
        check("rst_max", max_out, 16'h8000);

        // Release: rst_out high for 6 cycles, then ready 4 cycles later.
        rst_in = 1'b0;
        n = 0;
        do begin step(); n++; end while (rst_out === 1'b1 && n < 50);
        check("rst_hold_len", n, 6);
        n = 0;
        do begin step(); n++; end while (ready_out !== 1'b1 && n < 50);
        check("settle_len", n, 4);

        // Copy / invert routing and LEDs.
        adc_in[2*W +: W] = 16'h1234;
        sel0_in = 2'd2; mode0_in = 2'd0; sel1_in = 2'd2; mode1_in = 2'd1;
        step();
        check("copy_dac0", dac0_out, 16'h1234);
        check("inv_dac1", dac1_out, 16'hEDCB);
        check("led_ch2", led_out, 4'hE);

        adc_in[1*W +: W] = 16'h8001; sel0_in = 2'd1;
        step();
        check("copy_ch1", dac0_out, 16'h8001);
        check("led_ch1", led_out, 4'h7);
        check("dac1_steady", dac1_out, 16'hEDCB);

        mode0_in = 2'd3; adc_in[1*W +: W] = 16'h0F0F;
        step();
        check("hold_dac0", dac0_out, 16'h8001);
        check("led_hold", led_out, 4'hF);

        // Ramp from midscale through 0x7FF8 and wrap.
        mode0_in = 2'd2;
        step(); check("ramp_0", dac0_out, 16'h8000);
        step(); check("ramp_1", dac0_out, 16'h8008);
        repeat (8190) step();
        check("ramp_top", dac0_out, 16'h7FF8);
        step(); check("ramp_wrap", dac0_out, 16'h8000);
        mode0_in = 2'd0;
        step(); check("ramp_exit", dac0_out, 16'h0F0F);
        mode0_in = 2'd2;
        step(); check("ramp_reenter", dac0_out, 16'h8000);
        mode0_in = 2'd0;

        // Min/max on channel 0.
        sel0_in = 2'd0; adc_in[0 +: W] = 16'h0000; clr_stats_in = 1'b1;
        step(); clr_stats_in = 1'b0;
        check("clr_min", min_out, 16'h7FFF);
        check("clr_max", max_out, 16'h8000);
        adc_in[0 +: W] = 16'h0005; step();
        adc_in[0 +: W] = 16'hFED4; step();
        adc_in[0 +: W] = 16'h04B0; step();
        check("stat_min", min_out, 16'hFED4);
        check("stat_max", max_out, 16'h04B0);
        clr_stats_in = 1'b1; step(); clr_stats_in = 1'b0;
        check("clr2_min", min_out, 16'h7FFF);
        check("clr2_max", max_out, 16'h8000);
        adc_in[0 +: W] = 16'h0007; step();
        check("seven_min", min_out, 16'h0007);
        check("seven_max", max_out, 16'h0007);
        sel0_in = 2'd2; step();
        check("sel_noclr_min", min_out, 16'h0007);
        check("sel_noclr_max", max_out, 16'h1234);

        // Periodic auto-reset: rising edges 40 cycles apart.
        auto_en_in = 1'b1;
        wait_rise(n);
        check("auto_sync", (n < 200) ? 1 : 0, 1);
        for (int p = 0; p < 3; p++) begin
            wait_rise(n);
            check("auto_period", n, 40);
        end

        // Manual trigger coincident with auto-expiry, plus a trigger during hold: one pulse.
        repeat (39) step();
        check("pre_coinc_rst", rst_out, 0);
        check("pre_coinc_ready", ready_out, 1);
        trig_in = 1'b1; step(); trig_in = 1'b0;
        check("coinc_rise", rst_out, 1);
        step();
        trig_in = 1'b1; step(); trig_in = 1'b0;
        n = 2;
        do begin step(); n++; end while (rst_out === 1'b1 && n < 50);
        check("coinc_hold_len", n, 6);
        wait_rise(n);
        check("coinc_next_rise", n, 34);

        // Plain manual trigger in RUN.
        auto_en_in = 1'b0;
        n = 0;
        do begin step(); n++; end while (ready_out !== 1'b1 && n < 100);
        check("ready_before_trig", ready_out, 1);
        step();
        trig_in = 1'b1; step(); trig_in = 1'b0;
        check("trig_rst_out", rst_out, 1);
        check("trig_ready", ready_out, 0);
        n = 0;
        do begin step(); n++; end while (ready_out !== 1'b1 && n < 100);
        check("ready_after_trig", ready_out, 1);

        // Reset mid-RUN with DAC0 ramping and DAC1 holding.
        mode0_in = 2'd2; mode1_in = 2'd1; sel1_in = 2'd2;
        step();
        mode1_in = 2'd3;
        repeat (4) step();
        check("mid_ramp", dac0_out, 16'h8020);
        check("mid_hold", dac1_out, 16'hEDCB);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("midrst_dac0", dac0_out, 0);
        check("midrst_dac1", dac1_out, 0);
        check("midrst_rst_out", rst_out, 1);
        check("midrst_ready", ready_out, 0);
        check("midrst_min", min_out, 16'h7FFF);
        check("midrst_max", max_out, 16'h8000);
        check("midrst_led", led_out, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
